mem_arbiter_2to1: RTL and testbench

Two-requester memory arbiter that sits directly upstream of a single memory request/response port, such as one port of the test memory or a cache port. It merges two `vc-mem-msgs` request streams onto one stream using round-robin priority. It records the grant order in an in-flight tracking FIFO, so that in-order responses from memory are steered back to the requester that issued them. Message contents, including opaque, pass through untouched.

---
 rtl/mem_arbiter_2to1.sv | 107 ++++++++++
 tb/tb_mem_arbiter_2to1.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter_2to1.sv
// Two-to-one round-robin memory request arbiter with in-order response steering.
// A small FIFO of requester IDs routes each response back to the port that issued it.

`ifndef VC_MEM_REQ_MSG_NBITS
`define VC_MEM_REQ_MSG_NBITS(o_, a_, d_) (3 + (o_) + (a_) + $clog2((d_) / 8) + (d_))
`endif
`ifndef VC_MEM_RESP_MSG_NBITS
`define VC_MEM_RESP_MSG_NBITS(o_, d_) (3 + (o_) + 2 + $clog2((d_) / 8) + (d_))
`endif

module mem_arbiter_2to1 #(
  parameter int p_opaque_nbits = 8,
  parameter int p_addr_nbits   = 32,
  parameter int p_data_nbits   = 32,
  parameter int p_max_inflight = 4,
  localparam int c_req_nbits  = `VC_MEM_REQ_MSG_NBITS(p_opaque_nbits, p_addr_nbits, p_data_nbits),
  localparam int c_resp_nbits = `VC_MEM_RESP_MSG_NBITS(p_opaque_nbits, p_data_nbits)
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    req0_val,
  output logic                    req0_rdy,
  input  logic [c_req_nbits-1:0]  req0_msg,
  input  logic                    req1_val,
  output logic                    req1_rdy,
  input  logic [c_req_nbits-1:0]  req1_msg,
  output logic                    resp0_val,
  input  logic                    resp0_rdy,
  output logic [c_resp_nbits-1:0] resp0_msg,
  output logic                    resp1_val,
  input  logic                    resp1_rdy,
  output logic [c_resp_nbits-1:0] resp1_msg,
  output logic                    memreq_val,
  input  logic                    memreq_rdy,
  output logic [c_req_nbits-1:0]  memreq_msg,
  input  logic                    memresp_val,
  output logic                    memresp_rdy,
  input  logic [c_resp_nbits-1:0] memresp_msg
);

  localparam int c_ptr_nbits = $clog2(p_max_inflight);
  localparam int c_cnt_nbits = c_ptr_nbits + 1;

  logic                      prio;
  logic [p_max_inflight-1:0] ids;
  logic [c_ptr_nbits-1:0]    wr_ptr;
  logic [c_ptr_nbits-1:0]    rd_ptr;
  logic [c_cnt_nbits-1:0]    count;

  logic full, empty, head;
  logic gnt0, gnt1;
  logic req_fire, resp_fire;

  assign full  = (count == c_cnt_nbits'(p_max_inflight));
  assign empty = (count == '0);
  assign head  = ids[rd_ptr];

  assign gnt0 = req0_val & (~req1_val | ~prio);
  assign gnt1 = req1_val & (~req0_val | prio);

  // Reset gates every handshake output so nothing leaks while reset is low.
  assign memreq_val = reset & (req0_val | req1_val) & ~full;
  assign memreq_msg = gnt1 ? req1_msg : req0_msg;
  assign req0_rdy   = reset & gnt0 & memreq_rdy & ~full;
  assign req1_rdy   = reset & gnt1 & memreq_rdy & ~full;

  assign resp0_val   = reset & memresp_val & ~empty & ~head;
  assign resp1_val   = reset & memresp_val & ~empty & head;
  assign resp0_msg   = memresp_msg;
  assign resp1_msg   = memresp_msg;
  assign memresp_rdy = reset & ~empty & (head ? resp1_rdy : resp0_rdy);

  assign req_fire  = memreq_val & memreq_rdy;
  assign resp_fire = memresp_val & memresp_rdy;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      prio   <= 1'b0;
      ids    <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (req_fire) begin
        ids[wr_ptr] <= gnt1;
        wr_ptr      <= wr_ptr + c_ptr_nbits'(1);
        prio        <= ~gnt1;
      end
      if (resp_fire)
        rd_ptr <= rd_ptr + c_ptr_nbits'(1);
      case ({req_fire, resp_fire})
        2'b10:   count <= count + c_cnt_nbits'(1);
        2'b01:   count <= count - c_cnt_nbits'(1);
        default: count <= count;
      endcase
    end
  end

`ifndef SYNTHESIS
  a_resp_when_empty: assert property (@(posedge clk) disable iff (!reset) !(memresp_val && empty))
    else $error("memory response arrived with no request in flight");
  a_ctrl_known: assert property (@(posedge clk) disable iff (!reset)
    !$isunknown({req0_val, req1_val, memreq_rdy, memresp_val, resp0_rdy, resp1_rdy}))
    else $error("handshake control input is X");
`endif

endmodule

// File: tb/tb_mem_arbiter_2to1.sv
// Directed bench for mem_arbiter_2to1: reset, round-robin, full, ordering,
// backpressure and mid-operation reset, with hand-computed expectations.
module tb_mem_arbiter_2to1;
  localparam int REQ_W  = 77;
  localparam int RESP_W = 47;

  logic              clk = 1'b0;
  logic              reset;
  logic              req0_val, req0_rdy, req1_val, req1_rdy;
  logic [REQ_W-1:0]  req0_msg, req1_msg, memreq_msg;
  logic              resp0_val, resp0_rdy, resp1_val, resp1_rdy;
  logic [RESP_W-1:0] resp0_msg, resp1_msg, memresp_msg;
  logic              memreq_val, memreq_rdy, memresp_val, memresp_rdy;
  logic [5:0]        outs;

  int n_vec = 0;
  int n_err = 0;
  int q[$];

  always #5 clk = ~clk;

  mem_arbiter_2to1 dut (
    .clk(clk), .reset(reset),
    .req0_val(req0_val), .req0_rdy(req0_rdy), .req0_msg(req0_msg),
    .req1_val(req1_val), .req1_rdy(req1_rdy), .req1_msg(req1_msg),
    .resp0_val(resp0_val), .resp0_rdy(resp0_rdy), .resp0_msg(resp0_msg),
    .resp1_val(resp1_val), .resp1_rdy(resp1_rdy), .resp1_msg(resp1_msg),
    .memreq_val(memreq_val), .memreq_rdy(memreq_rdy), .memreq_msg(memreq_msg),
    .memresp_val(memresp_val), .memresp_rdy(memresp_rdy), .memresp_msg(memresp_msg)
  );

  assign outs = {req0_rdy, req1_rdy, resp0_val, resp1_val, memreq_val, memresp_rdy};

  function automatic logic [REQ_W-1:0] mk_req(input logic [2:0] t, input logic [7:0] o,
                                              input logic [31:0] a, input logic [31:0] d);
    return {t, o, a, 2'b00, d};
  endfunction

  function automatic logic [RESP_W-1:0] mk_resp(input logic [2:0] t, input logic [7:0] o,
                                                input logic [31:0] d);
    return {t, o, 2'b00, 2'b00, d};
  endfunction

  task automatic check_vec(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic idle_inputs();
    req0_val = 0; req1_val = 0; memreq_rdy = 0; memresp_val = 0;
    resp0_rdy = 0; resp1_rdy = 0;
    req0_msg = mk_req(3'd0, 8'h00, 32'h0, 32'h0);
    req1_msg = mk_req(3'd0, 8'h01, 32'h0, 32'h0);
    memresp_msg = '0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 0;
    idle_inputs();
    repeat (2) @(posedge clk);
    #4 reset = 1;
    tick();
    q.delete();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [REQ_W-1:0]  m;
    logic [RESP_W-1:0] r, ra, rb, rc;
    int g;

    // 1: reset forces outputs low, then a single port-0 read
    reset = 0;
    idle_inputs();
    req0_val = 1; req1_val = 1; memreq_rdy = 1; memresp_val = 1;
    resp0_rdy = 1; resp1_rdy = 1;
    tick();
    check_vec("rst_outs", outs, 6'b0);
    idle_inputs();
    #3 reset = 1;
    tick();
    m = mk_req(3'd0, 8'h11, 32'h1000, 32'h0);
    req0_val = 1; req0_msg = m; memreq_rdy = 1;
    #1;
    check_vec("rd_memreq_val", memreq_val, 1'b1);
    check_vec("rd_memreq_msg", memreq_msg, m);
    check_vec("rd_req_rdys", {req0_rdy, req1_rdy}, 2'b10);
    tick();
    req0_val = 0;
    r = mk_resp(3'd0, 8'h11, 32'hdeadbeef);
    memresp_val = 1; memresp_msg = r; resp0_rdy = 1; resp1_rdy = 1;
    #1;
    check_vec("rd_resp_vals", {resp0_val, resp1_val}, 2'b10);
    check_vec("rd_resp0_msg", resp0_msg, r);
    check_vec("rd_memresp_rdy", memresp_rdy, 1'b1);
    tick();
    memresp_val = 0;
    #1;
    check_vec("rd_drained", {resp0_val, resp1_val, memresp_rdy}, 3'b000);

    // 2: round-robin with responses drained each cycle
    do_reset();
    for (int i = 0; i < 8; i++) begin
      g = i % 2;
      req0_val = 1; req1_val = 1; memreq_rdy = 1; resp0_rdy = 1; resp1_rdy = 1;
      req0_msg = mk_req(3'd0, 8'h20, 32'h100 + i, 32'h0);
      req1_msg = mk_req(3'd0, 8'h21, 32'h200 + i, 32'h0);
      memresp_val = (q.size() > 0);
      memresp_msg = mk_resp(3'd0, 8'h30, 32'h5000 + i);
      #1;
      check_vec("rr_gnt", {req0_rdy, req1_rdy}, (g == 0) ? 2'b10 : 2'b01);
      check_vec("rr_msg", memreq_msg, (g == 0) ? req0_msg : req1_msg);
      if (q.size() > 0) begin
        check_vec("rr_resp_route", {resp0_val, resp1_val}, (q[0] == 0) ? 2'b10 : 2'b01);
        void'(q.pop_front());
      end
      q.push_back(g);
      tick();
    end
    idle_inputs();

    // 3: tracking FIFO full, one pop, exactly one new grant
    do_reset();
    req0_val = 1; req1_val = 1; memreq_rdy = 1;
    for (int i = 0; i < 4; i++) begin
      memresp_val = (i > 0);
      #1;
      check_vec("full_fill_gnt", {req0_rdy, req1_rdy}, (i % 2 == 0) ? 2'b10 : 2'b01);
      tick();
    end
    memresp_val = 1;
    #1;
    check_vec("full_blocked", {memreq_val, req0_rdy, req1_rdy, memresp_rdy}, 4'b0000);
    resp0_rdy = 1;
    #1;
    check_vec("full_pop", {memresp_rdy, resp0_val, resp1_val}, 3'b110);
    check_vec("full_no_bypass", memreq_val, 1'b0);
    tick();
    resp0_rdy = 0;
    #1;
    check_vec("full_regrant", {memreq_val, req0_rdy, req1_rdy}, 3'b110);
    tick();
    check_vec("full_again", memreq_val, 1'b0);
    idle_inputs();

    // 4: ordering and head-of-line blocking
    do_reset();
    memreq_rdy = 1;
    req0_val = 1; req0_msg = mk_req(3'd1, 8'h40, 32'h2000, 32'h12345678);
    #1;
    check_vec("ord_w0_gnt", {req0_rdy, req1_rdy}, 2'b10);
    tick();
    req0_val = 0;
    req1_val = 1; req1_msg = mk_req(3'd0, 8'h41, 32'h3000, 32'h0);
    #1;
    check_vec("ord_r1_gnt", {req0_rdy, req1_rdy}, 2'b01);
    check_vec("ord_r1_msg", memreq_msg, req1_msg);
    tick();
    req1_val = 0;
    req0_val = 1; req0_msg = mk_req(3'd0, 8'h42, 32'h2000, 32'h0);
    #1;
    check_vec("ord_r0_gnt", {req0_rdy, req1_rdy}, 2'b10);
    tick();
    req0_val = 0; memreq_rdy = 0;
    ra = mk_resp(3'd1, 8'h40, 32'h0);
    rb = mk_resp(3'd0, 8'h41, 32'hcafef00d);
    rc = mk_resp(3'd0, 8'h42, 32'h12345678);
    memresp_val = 1; memresp_msg = ra; resp0_rdy = 1; resp1_rdy = 0;
    #1;
    check_vec("ord_a_route", {resp0_val, resp1_val, memresp_rdy}, 3'b101);
    tick();
    memresp_msg = rb;
    #1;
    check_vec("ord_b_stall", {resp0_val, resp1_val, memresp_rdy}, 3'b010);
    for (int i = 0; i < 2; i++) begin
      tick();
      check_vec("ord_hol_block", {resp0_val, resp1_val, memresp_rdy}, 3'b010);
    end
    resp1_rdy = 1;
    #1;
    check_vec("ord_b_go", memresp_rdy, 1'b1);
    check_vec("ord_b_msg", resp1_msg, rb);
    tick();
    memresp_msg = rc; resp1_rdy = 0;
    #1;
    check_vec("ord_c_route", {resp0_val, resp1_val, memresp_rdy}, 3'b101);
    check_vec("ord_c_msg", resp0_msg, rc);
    tick();
    memresp_val = 0;
    check_vec("ord_count", dut.count, 3'd0);
    idle_inputs();

    // 5: request backpressure holds prio and count
    do_reset();
    req0_val = 1; memreq_rdy = 1;
    tick();
    req1_val = 1; memreq_rdy = 0;
    for (int i = 0; i < 5; i++) begin
      #1;
      check_vec("bp_rdys", {memreq_val, req0_rdy, req1_rdy}, 3'b100);
      tick();
    end
    check_vec("bp_prio", dut.prio, 1'b1);
    check_vec("bp_count", dut.count, 3'd1);
    memreq_rdy = 1;
    #1;
    check_vec("bp_release_gnt", {req0_rdy, req1_rdy}, 2'b01);
    tick();
    idle_inputs();

    // 6: asynchronous reset mid-operation
    do_reset();
    req0_val = 1; req1_val = 1; memreq_rdy = 1; resp0_rdy = 1; resp1_rdy = 1;
    repeat (3) tick();
    check_vec("mid_inflight", dut.count, 3'd3);
    #2 reset = 0;
    #1;
    check_vec("mid_outs", outs, 6'b0);
    check_vec("mid_count", dut.count, 3'd0);
    @(posedge clk);
    #4 reset = 1;
    #1;
    check_vec("mid_first_gnt", {req0_rdy, req1_rdy}, 2'b10);
    tick();
    idle_inputs();
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
